// File: rtl/s10000001_pattern_tx.sv
// ----------------------------------------------------------------------------
// s10000001_pattern_tx
//
// Serial pattern transmitter for the 1-0...0-1 framed line protocol. A burst
// is requested with start/reps. Each frame is a leading 1, ZEROS zeros and a
// trailing 1. Consecutive frames of a burst are separated by GAP idle zeros.
// The receiving end is the 1-0...0-1 sequence detector.
//
// Parameters
//   ZEROS : zero bits between the leading and trailing 1 (1 .. 2**CW)
//   CW    : width of the zero-run counter (2**CW >= ZEROS)
//   GAP   : idle zero bits between frames of one burst (0 .. 15)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   burst request, sampled only in IDLE
//   reps[3:0]  in   frames per burst, latched when start is accepted
//   abort      in   synchronous cancel of a burst in progress
//   J          out  serial pattern line
//   busy       out  high while a burst is in progress
//   frame_done out  one-cycle pulse in the TAIL cycle of every frame
//   done       out  one-cycle pulse in the cycle after the last TAIL
//
// All outputs are decoded from the state register only, so no input has a
// combinational path to any output.
// ----------------------------------------------------------------------------
module s10000001_pattern_tx #(
   parameter int ZEROS = 6,
   parameter int CW    = 3,
   parameter int GAP   = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] reps,
   input  logic       abort,
   output logic       J,
   output logic       busy,
   output logic       frame_done,
   output logic       done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LEAD = 3'd1;
   localparam logic [2:0] S_ZERO = 3'd2;
   localparam logic [2:0] S_TAIL = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;

   // Counters run down to 0 inclusive, so they are loaded with length-1.
   localparam logic [CW-1:0] ZERO_LOAD = CW'(ZEROS - 1);
   localparam int            GAP_M1    = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [3:0]    GAP_LOAD  = 4'(GAP_M1);

   logic [2:0]    state;
   logic [3:0]    rep_cnt;
   logic [CW-1:0] zero_cnt;
   logic [3:0]    gap_cnt;

   // Moore outputs. An illegal encoding matches none of these terms, so it
   // reads all zeros for the single cycle before it recovers to IDLE.
   assign J          = (state == S_LEAD) || (state == S_TAIL);
   assign busy       = (state == S_LEAD) || (state == S_ZERO) ||
                       (state == S_TAIL) || (state == S_GAP);
   assign frame_done = (state == S_TAIL);
   assign done       = (state == S_FIN);

   // NOTE: all state and counters update with non-blocking assignments so
   // every register samples pre-edge values regardless of statement order.
   // NOTE: the counters are reset too, so a burst after reset never sees
   // stale counts even though each counter is reloaded on state entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         rep_cnt  <= '0;
         zero_cnt <= '0;
         gap_cnt  <= '0;
      end else if (abort && busy) begin
         // Cancel wins over every other transition; no done pulse follows.
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               // reps=0 is a null request and leaves the block idle.
               if (start && (reps != 4'd0)) begin
                  rep_cnt <= reps;
                  state   <= S_LEAD;
               end
            end
            S_LEAD: begin
               zero_cnt <= ZERO_LOAD;
               state    <= S_ZERO;
            end
            S_ZERO: begin
               if (zero_cnt == '0) begin
                  state <= S_TAIL;
               end else begin
                  zero_cnt <= zero_cnt - 1'b1;
               end
            end
            S_TAIL: begin
               if (rep_cnt != 4'd0) begin
                  rep_cnt <= rep_cnt - 4'd1;
               end
               // rep_cnt still holds the pre-decrement count here, so 1
               // means this was the last frame.
               if (rep_cnt <= 4'd1) begin
                  state <= S_FIN;
               end else if (GAP == 0) begin
                  state <= S_LEAD;
               end else begin
                  gap_cnt <= GAP_LOAD;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= S_LEAD;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            S_FIN: begin
               // A start seen here is dropped; the next one is taken in IDLE.
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
